if_fetch: RTL

- Instruction-fetch stage: owns the PC, issues requests to the instruction memory, and drives the IF/ID pipeline register (pc, inst) consumed by the decode stage.
- Handles the MIPS branch delay slot. A redirect from decode (branch_flag/branch_addr) takes effect after the delay-slot instruction has been handed to decode.
- Supports memories with variable latency and downstream stalls. Holds at most one outstanding request.

---
 rtl/if_fetch_pkg.sv | 20 ++
 rtl/if_fetch_if.sv | 25 ++
 rtl/if_pc_next.sv | 30 +++
 rtl/if_fetch.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/if_fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage.
// Optional feature macro: IF_ALIGN_CHECK_EN (see if_fetch.sv).
package if_fetch_pkg;

    localparam int unsigned ADDR_BUS_W = 32;
    localparam int unsigned INST_BUS_W = 32;
    localparam int unsigned IF_STATE_W = 2;
    localparam int unsigned PC_STEP    = 4;

    localparam logic [INST_BUS_W-1:0] ZERO_WORD = 32'h0000_0000;

    // IF_STOP is only reachable when IF_ALIGN_CHECK_EN is defined.
    typedef enum logic [IF_STATE_W-1:0] {
        IF_IDLE  = 2'd0,
        IF_FETCH = 2'd1,
        IF_HOLD  = 2'd2,
        IF_STOP  = 2'd3
    } if_state_e;

endpackage

// File: rtl/if_fetch_if.sv
// Instruction-memory request/response bus between the fetch stage and memory.
interface if_fetch_if #(
    parameter int unsigned ADDR_W = 32
) ();

    logic              inst_req;
    logic [ADDR_W-1:0] inst_addr;
    logic              inst_ack;
    logic [ADDR_W-1:0] inst_rdata;

    modport master (
        output inst_req,
        output inst_addr,
        input  inst_ack,
        input  inst_rdata
    );

    modport slave (
        input  inst_req,
        input  inst_addr,
        output inst_ack,
        output inst_rdata
    );

endinterface

// File: rtl/if_pc_next.sv
// Next-PC select: pending branch target, else sequential PC (wraps mod 2^32).
// With IF_ALIGN_CHECK_EN defined, also flags a misaligned next PC.
module if_pc_next
    import if_fetch_pkg::*;
#(
    parameter int unsigned ADDR_W = 32
) (
    input  logic              br_pend,
    input  logic [ADDR_W-1:0] br_target,
    input  logic [ADDR_W-1:0] handed_pc,
    output logic [ADDR_W-1:0] next_pc_c
`ifdef IF_ALIGN_CHECK_EN
    ,
    output logic              misalign_c
`endif
);

    // Redirect wins over the sequential successor.
    always_comb begin
        next_pc_c = br_pend ? br_target : handed_pc + ADDR_W'(PC_STEP);
    end

`ifdef IF_ALIGN_CHECK_EN
    // Any set bit in [1:0] means the word address is not aligned.
    always_comb begin
        misalign_c = |next_pc_c[1:0];
    end
`endif

endmodule

// File: rtl/if_fetch.sv
// MIPS instruction-fetch stage: owns the PC, issues one outstanding request at
// a time, handles the branch delay slot and drives the IF/ID register.
// Optional macro IF_ALIGN_CHECK_EN adds the fetch_exc output and stops the
// stage on a misaligned next PC.
module if_fetch
    import if_fetch_pkg::*;
#(
    parameter int unsigned       ADDR_W   = ADDR_BUS_W,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall,
    input  logic              branch_flag,
    input  logic [ADDR_W-1:0] branch_addr,
    if_fetch_if.master        mem,
    output logic [ADDR_W-1:0] pc,
    output logic [ADDR_W-1:0] inst,
    output logic              inst_valid
`ifdef IF_ALIGN_CHECK_EN
    ,
    output logic              fetch_exc
`endif
);

    if_state_e         state, state_d;
    logic              req_q, req_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [ADDR_W-1:0] pc_d, inst_d;
    logic              valid_d;
    logic              br_pend, br_pend_d;
    logic [ADDR_W-1:0] br_target, br_target_d;
    logic              buf_valid, buf_valid_d;
    logic [ADDR_W-1:0] buf_pc, buf_pc_d;
    logic [ADDR_W-1:0] buf_inst, buf_inst_d;
`ifdef IF_ALIGN_CHECK_EN
    logic              exc_d;
    logic              misalign_c;
`endif

    logic              br_cap_c;
    logic              handoff_c;
    logic              sel_pend_c;
    logic [ADDR_W-1:0] sel_target_c;
    logic [ADDR_W-1:0] handed_pc_c;
    logic [ADDR_W-1:0] next_pc_c;

    assign mem.inst_req  = req_q;
    assign mem.inst_addr = addr_q;

    // Branch capture, handoff detection and the effective redirect for this handoff.
    always_comb begin
        br_cap_c     = branch_flag & ~stall & inst_valid;
        handoff_c    = ((state == IF_FETCH) & mem.inst_ack & ~stall)
                     | ((state == IF_HOLD) & buf_valid & ~stall);
        sel_pend_c   = br_pend | br_cap_c;
        sel_target_c = br_cap_c ? branch_addr : br_target;
        handed_pc_c  = (state == IF_HOLD) ? buf_pc : addr_q;
    end

    if_pc_next #(
        .ADDR_W     (ADDR_W)
    ) u_pc_next (
        .br_pend    (sel_pend_c),
        .br_target  (sel_target_c),
        .handed_pc  (handed_pc_c),
        .next_pc_c  (next_pc_c)
`ifdef IF_ALIGN_CHECK_EN
        ,
        .misalign_c (misalign_c)
`endif
    );

    // Next-state and IF/ID / request / buffer update.
    always_comb begin
        state_d     = state;
        req_d       = req_q;
        addr_d      = addr_q;
        pc_d        = pc;
        inst_d      = inst;
        valid_d     = inst_valid;
        br_pend_d   = br_pend;
        br_target_d = br_target;
        buf_valid_d = buf_valid;
        buf_pc_d    = buf_pc;
        buf_inst_d  = buf_inst;
`ifdef IF_ALIGN_CHECK_EN
        exc_d       = fetch_exc;
`endif

        if (br_cap_c) begin
            br_pend_d   = 1'b1;
            br_target_d = branch_addr;
        end

        case (state)
            IF_IDLE: begin
                req_d   = 1'b1;
                state_d = IF_FETCH;
            end
            IF_FETCH: begin
                if (mem.inst_ack) begin
                    if (!stall) begin
                        pc_d    = addr_q;
                        inst_d  = mem.inst_rdata;
                        valid_d = 1'b1;
                    end else begin
                        buf_valid_d = 1'b1;
                        buf_pc_d    = addr_q;
                        buf_inst_d  = mem.inst_rdata;
                        req_d       = 1'b0;
                        state_d     = IF_HOLD;
                    end
                end else if (!stall) begin
                    inst_d  = ADDR_W'(ZERO_WORD);
                    valid_d = 1'b0;
                end
            end
            IF_HOLD: begin
                if (!stall) begin
                    pc_d        = buf_pc;
                    inst_d      = buf_inst;
                    valid_d     = 1'b1;
                    buf_valid_d = 1'b0;
                end
            end
`ifdef IF_ALIGN_CHECK_EN
            IF_STOP: begin
                // Deliver the exception entry once, then present bubbles.
                if (!stall) begin
                    if (!fetch_exc) begin
                        pc_d    = addr_q;
                        inst_d  = ADDR_W'(ZERO_WORD);
                        valid_d = 1'b1;
                        exc_d   = 1'b1;
                    end else begin
                        inst_d  = ADDR_W'(ZERO_WORD);
                        valid_d = 1'b0;
                    end
                end
            end
`endif
            default: begin
                state_d = IF_IDLE;
                req_d   = 1'b0;
            end
        endcase

        // An instruction went to ID: launch the fetch of its successor.
        if (handoff_c) begin
            br_pend_d = 1'b0;
            req_d     = 1'b1;
            addr_d    = next_pc_c;
            state_d   = IF_FETCH;
`ifdef IF_ALIGN_CHECK_EN
            if (misalign_c) begin
                req_d   = 1'b0;
                state_d = IF_STOP;
            end
`endif
        end
    end

    // State, request and IF/ID registers with asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IF_IDLE;
            req_q      <= 1'b0;
            addr_q     <= RESET_PC;
            pc         <= '0;
            inst       <= ADDR_W'(ZERO_WORD);
            inst_valid <= 1'b0;
            br_pend    <= 1'b0;
            br_target  <= '0;
            buf_valid  <= 1'b0;
            buf_pc     <= '0;
            buf_inst   <= '0;
`ifdef IF_ALIGN_CHECK_EN
            fetch_exc  <= 1'b0;
`endif
        end else begin
            state      <= state_d;
            req_q      <= req_d;
            addr_q     <= addr_d;
            pc         <= pc_d;
            inst       <= inst_d;
            inst_valid <= valid_d;
            br_pend    <= br_pend_d;
            br_target  <= br_target_d;
            buf_valid  <= buf_valid_d;
            buf_pc     <= buf_pc_d;
            buf_inst   <= buf_inst_d;
`ifdef IF_ALIGN_CHECK_EN
            fetch_exc  <= exc_d;
`endif
        end
    end

endmodule
